// File: rtl/eq_output_limiter_if.sv
// Sample-pair handshake between the equalizer outputs, the limiter and the DAC write port.
interface eq_output_limiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] l_in;
    logic [DATA_W-1:0] r_in;
    logic              out_allowed;
    logic              out_valid;
    logic [DATA_W-1:0] l_out;
    logic [DATA_W-1:0] r_out;

    modport master (
        output in_valid, l_in, r_in, out_allowed,
        input  in_ready, out_valid, l_out, r_out
    );

    modport slave (
        input  in_valid, l_in, r_in, out_allowed,
        output in_ready, out_valid, l_out, r_out
    );
endinterface

// File: rtl/eq_output_limiter.sv
// Stereo limiter: shared gain envelope (fast attack, slow release) followed by a hard clip,
// holding each processed pair until the codec controller accepts it.
module eq_output_limiter #(
    parameter int unsigned       DATA_W       = 32,
    parameter logic [DATA_W-1:0] THRESH       = DATA_W'(32'h4000_0000),
    parameter int unsigned       ATTACK_SHIFT = 3,
    parameter logic [15:0]       RELEASE_STEP = 16'd4,
    parameter logic [15:0]       MIN_GAIN     = 16'h0800
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    eq_output_limiter_if.slave  bus,
    output logic                limiting,
    output logic [15:0]         gain,
    output logic [15:0]         clip_count
);

    localparam int unsigned PW = DATA_W + 17;
    localparam logic [15:0] UNITY = 16'h8000;
    localparam logic signed [DATA_W-1:0] THR_P = THRESH;
    localparam logic signed [DATA_W-1:0] THR_N = -THR_P;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, MULT, CLAMP, OUT} state_e;

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  l_in_q, l_in_d, r_in_q, r_in_d;
    logic signed [DATA_W-1:0]  gl_q, gl_d, gr_q, gr_d;
    logic        [DATA_W-1:0]  l_out_q, l_out_d, r_out_q, r_out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic                      limiting_q, limiting_d;
    logic        [15:0]        gain_q, gain_d;
    logic        [15:0]        clip_q, clip_d;

    logic signed [PW-1:0]      prod_l, prod_r;
    logic                      clip_l, clip_r;
    logic        [DATA_W-1:0]  abs_l, abs_r, peak;
    logic        [15:0]        gain_dec;
    logic        [16:0]        gain_inc;

    // |x| with the most negative code saturating to the largest positive code
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        if (x == MOST_NEG) return MOST_POS;
        if (x[DATA_W-1])   return DATA_W'(-x);
        return DATA_W'(x);
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic signed [DATA_W-1:0] x);
        if (x > THR_P) return DATA_W'(THR_P);
        if (x < THR_N) return DATA_W'(THR_N);
        return DATA_W'(x);
    endfunction

    always_comb begin
        state_d     = state_q;
        l_in_d      = l_in_q;
        r_in_d      = r_in_q;
        gl_d        = gl_q;
        gr_d        = gr_q;
        l_out_d     = l_out_q;
        r_out_d     = r_out_q;
        out_valid_d = out_valid_q;
        gain_d      = gain_q;
        clip_d      = clip_q;

        prod_l   = $signed(PW'(l_in_q)) * $signed(PW'({1'b0, gain_q}));
        prod_r   = $signed(PW'(r_in_q)) * $signed(PW'({1'b0, gain_q}));
        clip_l   = (gl_q > THR_P) || (gl_q < THR_N);
        clip_r   = (gr_q > THR_P) || (gr_q < THR_N);
        abs_l    = abs_sat(gl_q);
        abs_r    = abs_sat(gr_q);
        peak     = (abs_l > abs_r) ? abs_l : abs_r;
        gain_dec = gain_q - (gain_q >> ATTACK_SHIFT);
        gain_inc = 17'(gain_q) + 17'(RELEASE_STEP);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    l_in_d  = $signed(bus.l_in);
                    r_in_d  = $signed(bus.r_in);
                    state_d = MULT;
                end
            end
            MULT: begin
                gl_d    = DATA_W'(prod_l >>> 15);
                gr_d    = DATA_W'(prod_r >>> 15);
                state_d = CLAMP;
            end
            CLAMP: begin
                l_out_d     = clamp(gl_q);
                r_out_d     = clamp(gr_q);
                out_valid_d = 1'b1;
                if ((clip_l || clip_r) && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
                // gain moves only after this pair's products were taken
                if (peak > THRESH) gain_d = (gain_dec < MIN_GAIN) ? MIN_GAIN : gain_dec;
                else               gain_d = (gain_inc > 17'(UNITY)) ? UNITY : gain_inc[15:0];
                state_d = OUT;
            end
            OUT: begin
                if (out_valid_q && bus.out_allowed) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        limiting_d = (gain_d != UNITY);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            l_in_q      <= '0;
            r_in_q      <= '0;
            gl_q        <= '0;
            gr_q        <= '0;
            l_out_q     <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            limiting_q  <= 1'b0;
            gain_q      <= UNITY;
            clip_q      <= '0;
        end else begin
            state_q     <= state_d;
            l_in_q      <= l_in_d;
            r_in_q      <= r_in_d;
            gl_q        <= gl_d;
            gr_q        <= gr_d;
            l_out_q     <= l_out_d;
            r_out_q     <= r_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            limiting_q  <= limiting_d;
            gain_q      <= gain_d;
            clip_q      <= clip_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.l_out     = l_out_q;
    assign bus.r_out     = r_out_q;
    assign limiting      = limiting_q;
    assign gain          = gain_q;
    assign clip_count    = clip_q;

endmodule
